// File: rtl/simd_operand_loader_if.sv
// ============================================================================
// Module   : simd_operand_loader_if
// Purpose  : Element stream handshake plus operand/control bundle of the loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface simd_operand_loader_if #(
  parameter int ELEM_W = 16,
  parameter int N_ELEM = 16
);
  localparam int c_mat_w = ELEM_W * N_ELEM;

  logic              in_valid;
  logic              in_ready;
  logic [ELEM_W-1:0] in_data;
  logic              flush;
  logic [c_mat_w-1:0] Matrix_A;
  logic [c_mat_w-1:0] Matrix_B;
  logic              enable;
  logic              done;
  logic              busy;
  logic [4:0]        elem_idx;

  modport master (
    output in_valid, in_data, flush,
    input  in_ready, Matrix_A, Matrix_B, enable, done, busy, elem_idx
  );

  modport slave (
    input  in_valid, in_data, flush,
    output in_ready, Matrix_A, Matrix_B, enable, done, busy, elem_idx
  );
endinterface

`default_nettype wire

// File: rtl/simd_operand_loader.sv
// ============================================================================
// Module   : simd_operand_loader
// Purpose  : Assembles operand matrices A and B from an element stream, then
//            runs the SIMD array for a fixed number of cycles and pulses done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module simd_operand_loader #(
  parameter int ELEM_W         = 16,
  parameter int N_ELEM         = 16,
  parameter int COMPUTE_CYCLES = 4
) (
  input  logic                   CLK,
  input  logic                   reset,
  simd_operand_loader_if.slave   bus
);

  localparam int         c_mat_w    = ELEM_W * N_ELEM;
  localparam int         c_idx_w    = $clog2(N_ELEM);
  localparam logic [4:0] c_last     = 5'(N_ELEM - 1);
  localparam logic [7:0] c_cnt_last = 8'(COMPUTE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            r_state;
  logic [4:0]        r_idx;
  logic [7:0]        r_cnt;
  logic              r_ready;
  logic              r_enable;
  logic              r_done;
  logic              r_busy;
  logic [ELEM_W-1:0] r_a [N_ELEM];
  logic [ELEM_W-1:0] r_b [N_ELEM];

  logic w_beat;
  logic w_wr_a;
  logic w_wr_b;

  // flush blocks acceptance in the same cycle it aborts the load
  assign bus.in_ready = r_ready & ~bus.flush;
  assign w_beat       = bus.in_valid & bus.in_ready;
  assign w_wr_a       = w_beat & (r_state == LOAD_A);
  assign w_wr_b       = w_beat & (r_state == LOAD_B);

  assign bus.enable   = r_enable;
  assign bus.done     = r_done;
  assign bus.busy     = r_busy;
  assign bus.elem_idx = r_idx;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state  <= LOAD_A;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_ready  <= 1'b1;
      r_enable <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        LOAD_A: begin
          if (bus.flush) begin
            r_idx <= '0;
          end else if (w_beat) begin
            if (r_idx == c_last) begin
              r_idx   <= '0;
              r_state <= LOAD_B;
            end else begin
              r_idx <= r_idx + 5'd1;
            end
          end
        end
        LOAD_B: begin
          if (bus.flush) begin
            r_idx   <= '0;
            r_state <= LOAD_A;
          end else if (w_beat) begin
            if (r_idx == c_last) begin
              r_idx    <= '0;
              r_cnt    <= '0;
              r_state  <= COMPUTE;
              r_ready  <= 1'b0;
              r_enable <= 1'b1;
              r_busy   <= 1'b1;
            end else begin
              r_idx <= r_idx + 5'd1;
            end
          end
        end
        COMPUTE: begin
          if (r_cnt == c_cnt_last) begin
            r_state  <= DONE;
            r_enable <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          r_state <= LOAD_A;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state  <= LOAD_A;
          r_idx    <= '0;
          r_ready  <= 1'b1;
          r_enable <= 1'b0;
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_a <= '{default: '0};
      r_b <= '{default: '0};
    end else begin
      if (w_wr_a) r_a[r_idx[c_idx_w-1:0]] <= bus.in_data;
      if (w_wr_b) r_b[r_idx[c_idx_w-1:0]] <= bus.in_data;
    end
  end

  // Element 0 sits in the most significant slot of each packed matrix
  for (genvar k = 0; k < N_ELEM; k++) begin : g_pack
    assign bus.Matrix_A[c_mat_w-1-ELEM_W*k -: ELEM_W] = r_a[k];
    assign bus.Matrix_B[c_mat_w-1-ELEM_W*k -: ELEM_W] = r_b[k];
  end

endmodule

`default_nettype wire

// File: tb/tb_simd_operand_loader.sv
// ============================================================================
// Module   : tb_simd_operand_loader
// Purpose  : Self-checking bench for simd_operand_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simd_operand_loader;

  localparam int CC = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  simd_operand_loader_if #(.ELEM_W(16), .N_ELEM(16)) bus ();
  simd_operand_loader_if #(.ELEM_W(16), .N_ELEM(16)) bus1 ();

  simd_operand_loader #(.ELEM_W(16), .N_ELEM(16), .COMPUTE_CYCLES(CC)) dut (
    .CLK(clk), .reset(rst_n), .bus(bus)
  );
  simd_operand_loader #(.ELEM_W(16), .N_ELEM(16), .COMPUTE_CYCLES(1)) dut1 (
    .CLK(clk), .reset(rst_n), .bus(bus1)
  );

  int checks = 0;
  int errors = 0;

  // Reference: a job is 32 accepted elements followed by CC+1 blocked cycles
  // (CC with enable, then one done cycle).
  int          m_n;
  int          m_stall;
  int          m_jobs;
  bit          m_beat;
  logic [15:0] m_a [16];
  logic [15:0] m_b [16];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pack(input logic [15:0] m [16]);
    logic [255:0] v = '0;
    for (int k = 0; k < 16; k++) v = {v[239:0], m[k]};
    return v;
  endfunction

  task automatic model_reset();
    m_n = 0; m_stall = 0; m_beat = 1'b0;
    for (int k = 0; k < 16; k++) begin m_a[k] = '0; m_b[k] = '0; end
  endtask

  // One clock cycle on the CC=4 DUT: apply inputs, advance model, compare all outputs.
  task automatic cycle(input bit v, input logic [15:0] d, input bit f);
    bus.in_valid = v; bus.in_data = d; bus.flush = f;
    #1;
    check("in_ready", 256'(bus.in_ready), 256'(m_stall == 0 && !f));
    @(posedge clk);
    m_beat = v && (m_stall == 0) && !f;
    if (m_stall == 0 && f) begin
      m_n = 0;
    end else if (m_beat) begin
      if (m_n < 16) m_a[m_n] = d; else m_b[m_n-16] = d;
      m_n++;
      if (m_n == 32) begin m_n = 0; m_stall = CC + 1; end
    end else if (m_stall > 0) begin
      m_stall--;
    end
    #1;
    check("enable",   256'(bus.enable),   256'(m_stall > 1));
    check("done",     256'(bus.done),     256'(m_stall == 1));
    check("busy",     256'(bus.busy),     256'(m_stall > 0));
    check("elem_idx", 256'(bus.elem_idx), 256'(m_n % 16));
    check("Matrix_A", bus.Matrix_A, pack(m_a));
    check("Matrix_B", bus.Matrix_B, pack(m_b));
    if (m_stall == 1) m_jobs++;
  endtask

  task automatic send(input logic [15:0] d);
    int n = 0;
    do begin
      cycle(1'b1, d, 1'b0);
      n++;
    end while (!m_beat && n < 50);
    if (!m_beat) check("send_timeout", 256'(n), 256'(0));
  endtask

  typedef struct {
    bit          valid;
    logic [15:0] data;
    bit          en;
    bit          dn;
    bit          bz;
    logic [4:0]  idx;
  } vec_t;

  vec_t         tbl [37];
  logic [15:0]  exp_a [16];
  logic [255:0] exp_pack;
  int           cnt, start_jobs, j, done_seen;
  int           done_t [$];
  int           en_cnt;

  initial begin
    bus.in_valid = 0; bus.in_data = '0; bus.flush = 0;
    bus1.in_valid = 0; bus1.in_data = '0; bus1.flush = 0;
    m_jobs = 0;
    model_reset();

    // Full-rate job vectors: expectations follow the documented latency.
    for (int i = 0; i < 37; i++) begin
      if (i < 32)
        tbl[i] = '{1'b1, (i < 16) ? 16'(i + 1) : 16'(16'h0101 + i - 16),
                   (i == 31), 1'b0, (i == 31), 5'((i + 1) % 16)};
      else
        tbl[i] = '{1'b0, 16'h0, (i < 35), (i == 35), (i < 36), 5'd0};
    end

    // Reset state
    rst_n = 1'b0;
    #23;
    check("rst_enable", 256'(bus.enable), 256'(0));
    check("rst_done",   256'(bus.done),   256'(0));
    check("rst_busy",   256'(bus.busy),   256'(0));
    check("rst_idx",    256'(bus.elem_idx), 256'(0));
    check("rst_A",      bus.Matrix_A, 256'(0));
    check("rst_B",      bus.Matrix_B, 256'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready",  256'(bus.in_ready), 256'(1));

    // Full-rate stream from the table
    for (int i = 0; i < 37; i++) begin
      cycle(tbl[i].valid, tbl[i].data, 1'b0);
      check("tbl_enable", 256'(bus.enable),   256'(tbl[i].en));
      check("tbl_done",   256'(bus.done),     256'(tbl[i].dn));
      check("tbl_busy",   256'(bus.busy),     256'(tbl[i].bz));
      check("tbl_idx",    256'(bus.elem_idx), 256'(tbl[i].idx));
    end
    check("tbl_A_first", 256'(bus.Matrix_A[255:240]), 256'(16'h0001));
    check("tbl_A_last",  256'(bus.Matrix_A[15:0]),    256'(16'h0010));
    check("tbl_B_last",  256'(bus.Matrix_B[15:0]),    256'(16'h0110));

    // Same stream with valid toggling every cycle
    start_jobs = m_jobs; j = 0;
    for (int i = 0; i < 200 && m_jobs == start_jobs; i++) begin
      cycle((i % 2) == 0 && j < 32, (j < 16) ? 16'(j + 1) : 16'(16'h0101 + j - 16), 1'b0);
      if (m_beat) j++;
    end
    check("toggle_jobs",   256'(m_jobs - start_jobs), 256'(1));
    check("toggle_A_last", 256'(bus.Matrix_A[15:0]),  256'(16'h0010));
    check("toggle_B_first",256'(bus.Matrix_B[255:240]), 256'(16'h0101));
    cycle(1'b0, 16'h0, 1'b0);

    // Flush after 7 A beats, then a complete reload
    for (int k = 0; k < 7; k++) send(16'h5500 + 16'(k));
    cycle(1'b0, 16'h0, 1'b1);
    check("flush_idx", 256'(bus.elem_idx), 256'(0));
    start_jobs = m_jobs;
    for (int k = 0; k < 16; k++) begin
      exp_a[k] = 16'hA000 + 16'(k);
      send(exp_a[k]);
    end
    for (int k = 0; k < 16; k++) send(16'hB000 + 16'(k));
    exp_pack = pack(exp_a);
    check("flush_A", bus.Matrix_A, exp_pack);

    // Hold 0xFFFF through COMPUTE/DONE; it lands in A[0] afterwards
    cnt = 0; done_seen = 0;
    do begin
      cycle(1'b1, 16'hFFFF, 1'b0);
      cnt++;
      if (bus.done) done_seen++;
    end while (!m_beat && cnt < 20);
    check("hold_wait",   256'(cnt), 256'(CC + 2));
    check("hold_dones",  256'(done_seen), 256'(1));
    check("hold_jobs",   256'(m_jobs - start_jobs), 256'(1));
    check("hold_A0",     256'(bus.Matrix_A[255:240]), 256'(16'hFFFF));
    check("hold_A_rest", 256'(bus.Matrix_A[239:0]), 256'(exp_pack[239:0]));
    cycle(1'b0, 16'h0, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 99) < 70, 16'($urandom), $urandom_range(0, 99) < 3);

    // Reset on the 2nd COMPUTE cycle
    cnt = 0;
    while (m_stall != 0 && cnt < 20) begin cycle(1'b0, 16'h0, 1'b0); cnt++; end
    cycle(1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 32; k++) send(16'h3000 + 16'(k));
    cycle(1'b0, 16'h0, 1'b0);
    check("pre_rst_enable", 256'(bus.enable), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_enable", 256'(bus.enable),   256'(0));
    check("async_A",      bus.Matrix_A,       256'(0));
    check("async_B",      bus.Matrix_B,       256'(0));
    check("async_idx",    256'(bus.elem_idx), 256'(0));
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    done_seen = 0;
    for (int i = 0; i < CC + 3; i++) begin
      cycle(1'b0, 16'h0, 1'b0);
      if (bus.done) done_seen++;
    end
    check("rst_no_done", 256'(done_seen), 256'(0));

    // COMPUTE_CYCLES=1 instance, back-to-back jobs at full rate
    en_cnt = 0;
    for (int i = 0; i < 90; i++) begin
      bus1.in_valid = 1'b1;
      bus1.in_data  = 16'(i);
      @(posedge clk); #1;
      if (bus1.done) done_t.push_back(i);
      if (bus1.enable) en_cnt++;
    end
    bus1.in_valid = 1'b0;
    check("cc1_enables", 256'(en_cnt), 256'(2));
    check("cc1_dones",   256'(done_t.size()), 256'(2));
    if (done_t.size() == 2)
      check("cc1_spacing", 256'(done_t[1] - done_t[0]), 256'(34));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
